// File: rtl/sd_stream_ctrl_if.sv
// SD controller sector-read port: request/address out of the streamer,
// accept/complete pulses back from the SD controller.
interface sd_stream_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_done;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_done);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_done);
endinterface

// File: rtl/sd_stream_ctrl.sv
// Sector-streaming controller: walks a track's sector addresses from a parameter
// table and issues one SD read at a time while the audio FIFO has room.
module sd_stream_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int SEL_W      = 2,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_START =
    {32'd10240000, 32'd10240000, 32'd5120000, 32'd512000},
  parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_END =
    {32'd16122368, 32'd16122368, 32'd9050112, 32'd4095488},
  parameter int SECTOR_BYTES = 512,
  parameter int USEDW_W      = 11,
  parameter int FIFO_DEPTH   = 1024,
  parameter int SECTOR_WORDS = 256,
  parameter int MARGIN       = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   i_track_sel,
  input  logic               i_play,
  input  logic               i_loop_en,
  input  logic [USEDW_W-1:0] i_fifo_usedw,
  sd_stream_ctrl_if.master   rd_if,
  output logic [SEL_W-1:0]   o_cur_track,
  output logic               o_playing,
  output logic               o_track_done,
  output logic [2:0]         o_state
);

  localparam int TH_INT = FIFO_DEPTH - SECTOR_WORDS - MARGIN;
  localparam logic [USEDW_W-1:0] TH = USEDW_W'(TH_INT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t             r_state, w_next;
  logic [SEL_W-1:0]   r_sel;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic               r_arm;
  logic               r_rd_req;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_playing;
  logic               r_track_done;

  logic [SEL_W-1:0]   w_sel_idx;
  logic               w_at_end;
  logic               w_advance;
  logic               w_wrap;
  logic               w_end_idle;
  logic               w_track_done;

  function automatic logic [ADDR_W-1:0] table_entry(
    input logic [NUM_TRACKS*ADDR_W-1:0] tbl, input logic [SEL_W-1:0] idx);
    return tbl[int'(idx)*ADDR_W +: ADDR_W];
  endfunction

  assign w_sel_idx = (int'(i_track_sel) < NUM_TRACKS) ? i_track_sel : '0;
  assign w_at_end  = (r_cur_addr == table_entry(TRACK_END, r_sel));

  always_comb begin
    w_next       = r_state;
    w_advance    = 1'b0;
    w_wrap       = 1'b0;
    w_end_idle   = 1'b0;
    w_track_done = 1'b0;
    case (r_state)
      IDLE:  if (i_play && r_arm) w_next = LOAD;
      LOAD:  w_next = CHECK;
      CHECK: begin
        if (!i_play)                  w_next = HOLD;
        else if (w_sel_idx != r_sel)  w_next = LOAD;
        else if (i_fifo_usedw < TH)   w_next = REQ;
      end
      REQ:   if (rd_if.rd_ack) w_next = WAIT;
      // An in-flight sector always completes; pause and track change wait for CHECK.
      WAIT: begin
        if (rd_if.rd_done) begin
          if (w_at_end) begin
            w_track_done = 1'b1;
            if (i_loop_en) begin
              w_wrap = 1'b1;
              w_next = CHECK;
            end else begin
              w_end_idle = 1'b1;
              w_next     = IDLE;
            end
          end else begin
            w_advance = 1'b1;
            w_next    = CHECK;
          end
        end
      end
      HOLD:  if (i_play) w_next = (w_sel_idx == r_sel) ? CHECK : LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_cur_addr   <= '0;
      r_arm        <= 1'b1;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_playing    <= 1'b0;
      r_track_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rd_req     <= (w_next == REQ);
      r_playing    <= (w_next == CHECK) || (w_next == REQ) || (w_next == WAIT);
      r_track_done <= w_track_done;
      if (w_next == REQ)
        r_rd_addr <= r_cur_addr;
      if (r_state == LOAD) begin
        r_sel      <= w_sel_idx;
        r_cur_addr <= table_entry(TRACK_START, w_sel_idx);
      end else if (w_wrap) begin
        r_cur_addr <= table_entry(TRACK_START, r_sel);
      end else if (w_advance) begin
        r_cur_addr <= r_cur_addr + ADDR_W'(SECTOR_BYTES);
      end
      // After a track ends, play must be seen low before another start is allowed.
      if (!i_play)
        r_arm <= 1'b1;
      else if (w_end_idle)
        r_arm <= 1'b0;
    end
  end

  assign rd_if.rd_req  = r_rd_req;
  assign rd_if.rd_addr = r_rd_addr;
  assign o_cur_track   = r_sel;
  assign o_playing     = r_playing;
  assign o_track_done  = r_track_done;
  assign o_state       = r_state;

endmodule

// File: doc/sd_stream_ctrl.md
# sd_stream_ctrl

Parametrised sector-streaming controller for the SD-card audio path. It sits between the switch/key user logic, the SD controller's read port and the audio sample FIFO. It selects one of NUM_TRACKS tracks from a parameter address table and issues one sector read at a time while the FIFO has room for a whole sector. It supports play, pause, loop and track changes made while a sector is in flight.

## Interface
Parameters:
- NUM_TRACKS, 4: number of entries in the track table.
- SEL_W, 2: width of track_sel; 2^SEL_W ≥ NUM_TRACKS.
- ADDR_W, 32: SD byte-address width.
- TRACK_START, {32'd10240000, 32'd10240000, 32'd5120000, 32'd512000}: flattened NUM_TRACKS×ADDR_W start addresses; entry 0 is in the LSBs.
- TRACK_END, {32'd16122368, 32'd16122368, 32'd9050112, 32'd4095488}: flattened last-sector addresses, inclusive.
- SECTOR_BYTES, 512: address step per sector.
- USEDW_W, 11: width of fifo_usedw.
- FIFO_DEPTH, 1024: FIFO depth in words.
- SECTOR_WORDS, 256: words written per sector.
- MARGIN, 20: extra words of headroom.

Ports:
- clk, in, 1: system clock; all logic runs on this clock.
- rst_n, in, 1: asynchronous active-low reset.
- track_sel, in, SEL_W: requested track. Values ≥ NUM_TRACKS are treated as track 0.
- play, in, 1: level; 1 = stream.
- loop_en, in, 1: level; 1 = restart the track at its end.
- fifo_usedw, in, USEDW_W: current FIFO fill level.
- rd_req, out, 1: sector read request.
- rd_addr, out, ADDR_W: sector byte address, valid while rd_req = 1.
- rd_ack, in, 1: SD controller has accepted the request (one-cycle pulse).
- rd_done, in, 1: sector fully written into the FIFO (one-cycle pulse).
- cur_track, out, SEL_W: track currently being streamed.
- playing, out, 1: 1 in CHECK, REQ and WAIT.
- track_done, out, 1: one-cycle pulse when the last sector of a track completes.
- state_o, out, 3: FSM state encoding, for debugging on LEDs.

## Operation
- Threshold: TH = FIFO_DEPTH − SECTOR_WORDS − MARGIN (default 748). A new sector is needed only when fifo_usedw < TH.
- States and encodings: IDLE=0, LOAD=1, CHECK=2, REQ=3, WAIT=4, HOLD=5.
- IDLE → LOAD when play = 1.
- LOAD (1 cycle): latches sel_q = track_sel and sets cur_addr = TRACK_START[sel_q]. Always → CHECK.
- CHECK:
  - play = 0 → HOLD.
  - track_sel ≠ sel_q → LOAD.
  - fifo_usedw < TH → REQ.
  - Otherwise stay in CHECK.
- REQ: rd_req = 1 and rd_addr = cur_addr. Both stay stable until rd_ack. On rd_ack → WAIT.
- WAIT: no aborts; an in-flight sector always completes. On rd_done:
  - cur_addr = TRACK_END[sel_q] and loop_en = 1: cur_addr ← TRACK_START[sel_q], pulse track_done, → CHECK.
  - cur_addr = TRACK_END[sel_q] and loop_en = 0: pulse track_done, → IDLE.
  - Otherwise: cur_addr ← cur_addr + SECTOR_BYTES, → CHECK.
- HOLD: cur_addr is retained.
  - play = 1 and track_sel = sel_q → CHECK (resume).
  - play = 1 and track_sel ≠ sel_q → LOAD.
- Track change: takes effect only from CHECK or HOLD, never in REQ or WAIT.
- IDLE after end of track: the FSM restarts only after play has been seen low and then high again (edge re-arm flag). It does not auto-restart while play is held high.
- Arithmetic: cur_addr is ADDR_W unsigned; the add wraps modulo 2^ADDR_W. The end test is an equality compare against the inclusive TRACK_END.
- Out-of-range track_sel is mapped to index 0 before the table lookup.

## Timing
- Reset values: rd_req = 0, rd_addr = 0, cur_track = 0, playing = 0, track_done = 0, state_o = 0 (IDLE), cur_addr = 0, re-arm flag = 1.
- All outputs are registered.
- From play rising in IDLE, rd_req asserts 3 cycles later (LOAD, CHECK, REQ), provided fifo_usedw < TH.
- rd_done → next rd_req: 2 cycles minimum (CHECK, REQ).
- rd_ack and rd_done in the same cycle while in REQ: treated as ack only. rd_done is honoured only in WAIT.
- rd_ack arriving outside REQ is ignored.
- Reset asserted mid-sector: everything returns to IDLE immediately. The SD controller shares the same reset.
- fifo_usedw is sampled in CHECK only.

## Test plan
- Reset, track_sel = 0, play = 1, usedw = 0: rd_req asserts at cycle 3 with rd_addr = 512000. Ack, then done: next rd_addr = 512512.
- usedw = 748 held in CHECK: no rd_req. Drop usedw to 747: rd_req asserts 1 cycle later.
- cur_addr = 4095488 with loop_en = 0: rd_done gives a track_done pulse and state_o = 0. With loop_en = 1: next rd_addr = 512000.
- track_sel 0 → 1 while in WAIT: the current sector completes. The next request uses rd_addr = 5120000 and cur_track = 1.
- play dropped in WAIT: rd_done is still accepted and the FSM enters HOLD. Raising play again resumes at cur_addr + 512.
- rst_n pulsed low mid-REQ: rd_req = 0 asynchronously and all outputs return to their reset values.
